// File: rtl/lcd_timing_pkg.sv
// Shared timing constants, widths and FSM state type for the LCD timing path.
package lcd_timing_pkg;

  localparam int unsigned COORD_W = 11;
  localparam int unsigned CNT_W   = 12;

  // 1280x720@60 (74.25 MHz pixel clock)
  localparam int unsigned HD_H_SYNC  = 40;
  localparam int unsigned HD_H_BACK  = 220;
  localparam int unsigned HD_H_DISP  = 1280;
  localparam int unsigned HD_H_FRONT = 110;
  localparam int unsigned HD_V_SYNC  = 5;
  localparam int unsigned HD_V_BACK  = 20;
  localparam int unsigned HD_V_DISP  = 720;
  localparam int unsigned HD_V_FRONT = 5;

  // 800x480 panel alternative
  localparam int unsigned WV_H_SYNC  = 128;
  localparam int unsigned WV_H_BACK  = 88;
  localparam int unsigned WV_H_DISP  = 800;
  localparam int unsigned WV_H_FRONT = 40;
  localparam int unsigned WV_V_SYNC  = 2;
  localparam int unsigned WV_V_BACK  = 33;
  localparam int unsigned WV_V_DISP  = 480;
  localparam int unsigned WV_V_FRONT = 10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STOP_PEND = 2'd2
  } lcd_state_t;

endpackage

// File: rtl/lcd_tcnt.sv
// Wrapping up-counter 0..MAX with a carry-out asserted on the wrapping cycle.
module lcd_tcnt #(
  parameter int unsigned W   = 12,
  parameter int unsigned MAX = 1649
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MAX);

  assign wrap = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (clr)
      cnt <= '0;
    else if (en)
      cnt <= wrap ? '0 : cnt + W'(1);
  end

endmodule

// File: rtl/lcd_timing_driver.sv
// Video timing generator with frame-aligned start/stop and a one-cycle
// registered DE/HS/VS/RGB output stage.
module lcd_timing_driver
  import lcd_timing_pkg::*;
#(
  parameter int unsigned H_SYNC   = HD_H_SYNC,
  parameter int unsigned H_BACK   = HD_H_BACK,
  parameter int unsigned H_DISP   = HD_H_DISP,
  parameter int unsigned H_FRONT  = HD_H_FRONT,
  parameter int unsigned V_SYNC   = HD_V_SYNC,
  parameter int unsigned V_BACK   = HD_V_BACK,
  parameter int unsigned V_DISP   = HD_V_DISP,
  parameter int unsigned V_FRONT  = HD_V_FRONT,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic        lcd_clk,
  input  logic        sys_rst,
  input  logic        disp_en,
  input  logic [23:0] pixel_data,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic        data_req,
  output logic        lcd_de,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic [23:0] lcd_rgb,
  output logic        frame_start,
  output logic [1:0]  dbg_state
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_LO   = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] H_ACT_HI   = CNT_W'(H_SYNC + H_BACK + H_DISP);
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] V_ACT_LO   = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] V_ACT_HI   = CNT_W'(V_SYNC + V_BACK + V_DISP);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);

  lcd_state_t       state;
  logic             running;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_wrap;
  logic             v_wrap;
  logic             hs_act;
  logic             vs_act;
  logic             h_act;
  logic             v_act;
  logic             frame_top;
  logic             frame_last;

  assign running = (state != IDLE);

  // Counters are cleared in IDLE so a restart always begins at (0,0).
  lcd_tcnt #(.W(CNT_W), .MAX(H_TOTAL - 1)) u_hcnt (
    .clk  (lcd_clk),
    .clr  (sys_rst || !running),
    .en   (running),
    .cnt  (h_cnt),
    .wrap (h_wrap)
  );

  lcd_tcnt #(.W(CNT_W), .MAX(V_TOTAL - 1)) u_vcnt (
    .clk  (lcd_clk),
    .clr  (sys_rst || !running),
    .en   (running && h_wrap),
    .cnt  (v_cnt),
    .wrap (v_wrap)
  );

  assign hs_act     = running && (h_cnt < H_SYNC_END);
  assign vs_act     = running && (v_cnt < V_SYNC_END);
  assign h_act      = (h_cnt >= H_ACT_LO) && (h_cnt < H_ACT_HI);
  assign v_act      = (v_cnt >= V_ACT_LO) && (v_cnt < V_ACT_HI);
  assign data_req   = running && h_act && v_act;
  assign frame_top  = running && (h_cnt == '0) && (v_cnt == '0);
  assign frame_last = (h_cnt == H_LAST) && (v_cnt == V_LAST);

  assign pixel_xpos = data_req ? COORD_W'(h_cnt - H_ACT_LO) : '0;
  assign pixel_ypos = data_req ? COORD_W'(v_cnt - V_ACT_LO) : '0;
  assign dbg_state  = state;

  // Stop is only honoured on the last pixel of a frame, never mid-frame.
  always_ff @(posedge lcd_clk) begin
    if (sys_rst) begin
      state       <= IDLE;
      lcd_de      <= 1'b0;
      lcd_rgb     <= '0;
      lcd_hs      <= ~SYNC_POL;
      lcd_vs      <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else begin
      case (state)
        IDLE:      if (disp_en) state <= RUN;
        RUN:       if (!disp_en) state <= STOP_PEND;
        STOP_PEND: begin
          if (disp_en)
            state <= RUN;
          else if (frame_last)
            state <= IDLE;
        end
        default:   state <= IDLE;
      endcase
      lcd_de      <= data_req;
      lcd_rgb     <= data_req ? pixel_data : '0;
      lcd_hs      <= hs_act ? SYNC_POL : ~SYNC_POL;
      lcd_vs      <= vs_act ? SYNC_POL : ~SYNC_POL;
      frame_start <= frame_top;
    end
  end

endmodule

// File: tb/tb_lcd_timing_driver.sv
// Bench for lcd_timing_driver using reduced timing sets so full frames,
// stop/restart and reset recovery fit in a short run.
module tb_lcd_timing_driver;

  // Instance A: active-low syncs. H 4/5/8/3 = 20, V 2/3/4/2 = 11, frame 220.
  localparam int A_HS = 4, A_HB = 5, A_HD = 8, A_HF = 3;
  localparam int A_VS = 2, A_VB = 3, A_VD = 4, A_VF = 2;
  localparam int A_HT = A_HS + A_HB + A_HD + A_HF;
  localparam int A_VT = A_VS + A_VB + A_VD + A_VF;
  localparam int A_F  = A_HT * A_VT;
  // Instance B: active-high syncs. H 3/4/6/2 = 15, V 1/2/3/1 = 7, frame 105.
  localparam int B_HS = 3, B_HB = 4, B_HD = 6, B_HF = 2;
  localparam int B_VS = 1, B_VB = 2, B_VD = 3, B_VF = 1;
  localparam int BIG  = 1 << 30;

  logic        lcd_clk = 1'b0;
  logic        sys_rst;
  logic        disp_en, disp_en_b;
  logic [23:0] pixel_data, pixel_data_b;
  logic [10:0] pixel_xpos, pixel_ypos, pixel_xpos_b, pixel_ypos_b;
  logic        data_req, lcd_de, lcd_hs, lcd_vs, frame_start;
  logic        data_req_b, lcd_de_b, lcd_hs_b, lcd_vs_b, frame_start_b;
  logic [23:0] lcd_rgb, lcd_rgb_b;
  logic [1:0]  dbg_state, dbg_state_b;

  int errors = 0;
  int checks = 0;
  int n = 0;
  int end_p = BIG;

  typedef struct {
    logic        req;
    logic [10:0] x;
    logic [10:0] y;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [23:0] rgb;
  } view_t;

  typedef struct {
    int          p;
    logic        req;
    logic [10:0] x;
    logic [10:0] y;
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [23:0] rgb;
  } vec_t;

  vec_t tbl[17];

  always #5 lcd_clk = ~lcd_clk;

  assign pixel_data   = {pixel_xpos[7:0], pixel_ypos[7:0], 8'hA5};
  assign pixel_data_b = {pixel_xpos_b[7:0], pixel_ypos_b[7:0], 8'h5A};

  lcd_timing_driver #(
    .H_SYNC(A_HS), .H_BACK(A_HB), .H_DISP(A_HD), .H_FRONT(A_HF),
    .V_SYNC(A_VS), .V_BACK(A_VB), .V_DISP(A_VD), .V_FRONT(A_VF),
    .SYNC_POL(1'b0)
  ) dut_a (
    .lcd_clk(lcd_clk), .sys_rst(sys_rst), .disp_en(disp_en),
    .pixel_data(pixel_data), .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
    .data_req(data_req), .lcd_de(lcd_de), .lcd_hs(lcd_hs), .lcd_vs(lcd_vs),
    .lcd_rgb(lcd_rgb), .frame_start(frame_start), .dbg_state(dbg_state)
  );

  lcd_timing_driver #(
    .H_SYNC(B_HS), .H_BACK(B_HB), .H_DISP(B_HD), .H_FRONT(B_HF),
    .V_SYNC(B_VS), .V_BACK(B_VB), .V_DISP(B_VD), .V_FRONT(B_VF),
    .SYNC_POL(1'b1)
  ) dut_b (
    .lcd_clk(lcd_clk), .sys_rst(sys_rst), .disp_en(disp_en_b),
    .pixel_data(pixel_data_b), .pixel_xpos(pixel_xpos_b), .pixel_ypos(pixel_ypos_b),
    .data_req(data_req_b), .lcd_de(lcd_de_b), .lcd_hs(lcd_hs_b), .lcd_vs(lcd_vs_b),
    .lcd_rgb(lcd_rgb_b), .frame_start(frame_start_b), .dbg_state(dbg_state_b)
  );

  // Instance B frame statistics, one window per frame_start-to-frame_start.
  int cyc_b = 0, de_nb = 0, hs_nb = 0, vs_nb = 0, frames_b = 0;
  int last_per_b = 0, last_de_b = 0, last_hs_b = 0, last_vs_b = 0;

  always @(negedge lcd_clk) begin
    if (sys_rst) begin
      cyc_b <= 0;
    end else if (frame_start_b) begin
      if (cyc_b > 0) begin
        last_per_b <= cyc_b;
        last_de_b  <= de_nb;
        last_hs_b  <= hs_nb;
        last_vs_b  <= vs_nb;
        frames_b   <= frames_b + 1;
      end
      cyc_b <= 1;
      de_nb <= int'(lcd_de_b);
      hs_nb <= int'(lcd_hs_b);
      vs_nb <= int'(lcd_vs_b);
    end else if (cyc_b > 0) begin
      cyc_b <= cyc_b + 1;
      de_nb <= de_nb + int'(lcd_de_b);
      hs_nb <= hs_nb + int'(lcd_hs_b);
      vs_nb <= vs_nb + int'(lcd_vs_b);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at n=%0d: got %0h, want %0h", name, n, act, exp);
    end
  endtask

  // Instance A expectation for counter position p since the run began.
  function automatic view_t model_at(input int p);
    view_t m;
    int q, h, v;
    m.req = 1'b0; m.x = '0; m.y = '0; m.hs = 1'b1; m.vs = 1'b1; m.fs = 1'b0; m.rgb = '0;
    if (p < 0 || p >= end_p) return m;
    q = p % A_F;
    h = q % A_HT;
    v = q / A_HT;
    m.req = (h >= A_HS + A_HB) && (h < A_HS + A_HB + A_HD) &&
            (v >= A_VS + A_VB) && (v < A_VS + A_VB + A_VD);
    if (m.req) begin
      m.x   = 11'(h - (A_HS + A_HB));
      m.y   = 11'(v - (A_VS + A_VB));
      m.rgb = {m.x[7:0], m.y[7:0], 8'hA5};
    end
    m.hs = !(h < A_HS);
    m.vs = !(v < A_VS);
    m.fs = (q == 0);
    return m;
  endfunction

  task automatic check_cycle();
    view_t c, r;
    c = model_at(n);
    r = model_at(n - 1);
    chk("data_req", data_req, c.req);
    chk("xpos", pixel_xpos, c.x);
    chk("ypos", pixel_ypos, c.y);
    chk("lcd_de", lcd_de, r.req);
    chk("lcd_rgb", lcd_rgb, r.rgb);
    chk("lcd_hs", lcd_hs, r.hs);
    chk("lcd_vs", lcd_vs, r.vs);
    chk("frame_start", frame_start, r.fs);
  endtask

  task automatic tick();
    @(posedge lcd_clk);
    #1;
    n++;
    check_cycle();
  endtask

  task automatic check_idle_a(input string tag);
    chk({tag, "_de"}, lcd_de, 1'b0);
    chk({tag, "_rgb"}, lcd_rgb, 24'h0);
    chk({tag, "_hs"}, lcd_hs, 1'b1);
    chk({tag, "_vs"}, lcd_vs, 1'b1);
    chk({tag, "_fs"}, frame_start, 1'b0);
    chk({tag, "_req"}, data_req, 1'b0);
    chk({tag, "_xy"}, {pixel_xpos, pixel_ypos}, 22'h0);
    chk({tag, "_state"}, dbg_state, 2'd0);
  endtask

  initial begin
    //        p    req   x      y      de    hs    vs    fs    rgb
    tbl[0]  = '{0,   1'b0, 11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000};
    tbl[1]  = '{1,   1'b0, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000000};
    tbl[2]  = '{4,   1'b0, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
    tbl[3]  = '{5,   1'b0, 11'd0, 11'd0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000};
    tbl[4]  = '{40,  1'b0, 11'd0, 11'd0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000};
    tbl[5]  = '{41,  1'b0, 11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000};
    tbl[6]  = '{109, 1'b1, 11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000};
    tbl[7]  = '{110, 1'b1, 11'd1, 11'd0, 1'b1, 1'b1, 1'b1, 1'b0, 24'h0000A5};
    tbl[8]  = '{116, 1'b1, 11'd7, 11'd0, 1'b1, 1'b1, 1'b1, 1'b0, 24'h0600A5};
    tbl[9]  = '{117, 1'b0, 11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 1'b0, 24'h0700A5};
    tbl[10] = '{118, 1'b0, 11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000};
    tbl[11] = '{176, 1'b1, 11'd7, 11'd3, 1'b1, 1'b1, 1'b1, 1'b0, 24'h0603A5};
    tbl[12] = '{178, 1'b0, 11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000};
    tbl[13] = '{189, 1'b0, 11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000};
    tbl[14] = '{219, 1'b0, 11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000};
    tbl[15] = '{220, 1'b0, 11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000};
    tbl[16] = '{221, 1'b0, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000000};

    sys_rst = 1'b1;
    disp_en = 1'b0;
    disp_en_b = 1'b0;
    repeat (3) @(posedge lcd_clk);
    #1;
    check_idle_a("rst");
    chk("rst_b_hs", lcd_hs_b, 1'b0);
    chk("rst_b_vs", lcd_vs_b, 1'b0);
    chk("rst_b_state", dbg_state_b, 2'd0);

    sys_rst = 1'b0;
    repeat (4) @(posedge lcd_clk);
    #1;
    check_idle_a("idle");
    disp_en_b = 1'b1;

    // First frame: hand-computed points at sync, porch and active edges.
    disp_en = 1'b1;
    @(posedge lcd_clk);
    #1;
    n = 0;
    end_p = BIG;
    check_cycle();
    for (int k = 0; k < 17; k++) begin
      while (n < tbl[k].p) tick();
      chk("tbl_req", data_req, tbl[k].req);
      chk("tbl_x", pixel_xpos, tbl[k].x);
      chk("tbl_y", pixel_ypos, tbl[k].y);
      chk("tbl_de", lcd_de, tbl[k].de);
      chk("tbl_hs", lcd_hs, tbl[k].hs);
      chk("tbl_vs", lcd_vs, tbl[k].vs);
      chk("tbl_fs", frame_start, tbl[k].fs);
      chk("tbl_rgb", lcd_rgb, tbl[k].rgb);
    end

    // Drop and restore inside one frame: timing must not move.
    while (n < A_F + 30) tick();
    disp_en = 1'b0;
    while (n < A_F + 40) tick();
    chk("state_stop_pend", dbg_state, 2'd2);
    while (n < A_F + 60) tick();
    disp_en = 1'b1;
    while (n < A_F + 70) tick();
    chk("state_run_again", dbg_state, 2'd1);

    // Drop on line 3 of frame 2: that frame completes, then silence.
    while (n < 2 * A_F + 3 * A_HT) tick();
    disp_en = 1'b0;
    end_p = 3 * A_F;
    while (n < 3 * A_F + 10) tick();
    chk("state_idle_after_stop", dbg_state, 2'd0);
    while (n < 3 * A_F + 20) tick();

    // Reset mid-frame on an active pixel, disp_en held high.
    disp_en = 1'b1;
    @(posedge lcd_clk);
    #1;
    n = 0;
    end_p = BIG;
    check_cycle();
    while (n < 5 * A_HT + 12) tick();
    chk("pre_rst_req", data_req, 1'b1);
    sys_rst = 1'b1;
    @(posedge lcd_clk);
    #1;
    check_idle_a("midrst");
    sys_rst = 1'b0;
    @(posedge lcd_clk);
    #1;
    n = 0;
    check_cycle();
    tick();
    chk("fs_after_rst", frame_start, 1'b1);
    while (n < 30) tick();

    // Active-high set: totals measured from frame_start to frame_start.
    chk("b_frames_seen", 32'(frames_b >= 2), 32'd1);
    chk("b_period", last_per_b, 32'd105);
    chk("b_de_cycles", last_de_b, 32'd18);
    chk("b_hs_high", last_hs_b, 32'd21);
    chk("b_vs_high", last_vs_b, 32'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
